// File: rtl/hazard_scoreboard.sv
// Load-use stall and EX-operand forwarding-select tracker for a 5-stage MIPS-style pipeline.
// Optional feature: define HAZARD_STALL_COUNT_EN to add a saturating stall_count output.
module hazard_scoreboard (
   input  logic       clk,
   input  logic       reset,
   input  logic       issue_valid,
   input  logic [4:0] issue_dst,
   input  logic       issue_we,
   input  logic       issue_is_load,
   input  logic [4:0] rs,
   input  logic [4:0] rt,
   input  logic       use_rs,
   input  logic       use_rt,
   input  logic       flush,
   output logic       stall,
   output logic [1:0] fwd_a,
   output logic [1:0] fwd_b
`ifdef HAZARD_STALL_COUNT_EN
   ,
   output logic [15:0] stall_count
`endif
);

   typedef struct packed {
      logic       valid;
      logic [4:0] dst;
      logic       is_load;
   } entry_t;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b10;  // operand from EX/MEM
   localparam logic [1:0] FWD_WB  = 2'b01;  // operand from MEM/WB

   entry_t     r_ex, r_mem, r_wb;
   entry_t     w_issue;
   logic [1:0] r_fwd_a, r_fwd_b;
   logic [1:0] w_fwd_a_nxt, w_fwd_b_nxt;
   logic       w_stall;
   logic       w_rs_ex, w_rt_ex, w_rs_mem, w_rt_mem;

   function automatic logic f_match(input logic [4:0] src, input logic use_src, input entry_t e);
      return e.valid && (e.dst == src) && (src != 5'd0) && use_src;
   endfunction

   // NOTE: every variable below gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_rs_ex  = f_match(rs, use_rs, r_ex);
      w_rt_ex  = f_match(rt, use_rt, r_ex);
      w_rs_mem = f_match(rs, use_rs, r_mem);
      w_rt_mem = f_match(rt, use_rt, r_mem);

      // Reset gates the stall directly so it drops without waiting for a clock edge.
      w_stall = !reset && issue_valid && !flush && r_ex.is_load && (w_rs_ex || w_rt_ex);

      w_issue = '0;
      if (issue_valid && issue_we && (issue_dst != 5'd0) && !w_stall && !flush) begin
         w_issue.valid   = 1'b1;
         w_issue.dst     = issue_dst;
         w_issue.is_load = issue_is_load;
      end

      w_fwd_a_nxt = FWD_RF;
      w_fwd_b_nxt = FWD_RF;
      if (issue_valid && !w_stall && !flush) begin
         // Youngest producer first: EX beats MEM for the same source register.
         if (w_rs_ex)       w_fwd_a_nxt = FWD_MEM;
         else if (w_rs_mem) w_fwd_a_nxt = FWD_WB;
         if (w_rt_ex)       w_fwd_b_nxt = FWD_MEM;
         else if (w_rt_mem) w_fwd_b_nxt = FWD_WB;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every stage shifts from pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ex    <= '0;
         r_mem   <= '0;
         r_wb    <= '0;
         r_fwd_a <= FWD_RF;
         r_fwd_b <= FWD_RF;
      end else begin
         r_wb    <= r_mem;
         r_mem   <= r_ex;
         r_ex    <= w_issue;
         r_fwd_a <= w_fwd_a_nxt;
         r_fwd_b <= w_fwd_b_nxt;
      end
   end

   // WB needs no forward (register file writes before it reads); it is kept for visibility only.
   a_wb_entry_clean: assert property (@(posedge clk) disable iff (reset)
      r_wb.valid ? (r_wb.dst != 5'd0) : (r_wb == '0));

`ifdef HAZARD_STALL_COUNT_EN
   logic [15:0] r_stall_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_stall_count <= '0;
      else if (w_stall && (r_stall_count != 16'hFFFF))
         r_stall_count <= r_stall_count + 16'd1;
   end

   assign stall_count = r_stall_count;
`endif

   assign stall = w_stall;
   assign fwd_a = r_fwd_a;
   assign fwd_b = r_fwd_b;

endmodule
